// File: rtl/wr_mem_arb.sv
// Round-robin arbiter giving NUM_SRCS write requesters turns on one write-memory port.
// A grant owns the port from the request handshake through the done handshake.
module wr_mem_arb #(
  parameter  int NUM_SRCS = 2,
  parameter  int ADDR_W   = 32,
  parameter  int SIZE_W   = 16,
  parameter  int DATA_W   = 512,
  localparam int ID_W     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRCS-1:0]          src_wr_mem_req_val,
  output logic [NUM_SRCS-1:0]          wr_mem_src_req_rdy,
  input  logic [NUM_SRCS*ADDR_W-1:0]   src_wr_mem_req_addr,
  input  logic [NUM_SRCS*SIZE_W-1:0]   src_wr_mem_req_size,
  input  logic [NUM_SRCS-1:0]          src_wr_mem_req_data_val,
  output logic [NUM_SRCS-1:0]          wr_mem_src_req_data_rdy,
  input  logic [NUM_SRCS*DATA_W-1:0]   src_wr_mem_req_data,
  output logic [NUM_SRCS-1:0]          wr_mem_src_wr_req_done,
  input  logic [NUM_SRCS-1:0]          src_wr_mem_wr_req_done_rdy,
  output logic                         arb_wr_mem_req_val,
  input  logic                         wr_mem_arb_req_rdy,
  output logic [ADDR_W-1:0]            arb_wr_mem_req_addr,
  output logic [SIZE_W-1:0]            arb_wr_mem_req_size,
  output logic                         arb_wr_mem_req_data_val,
  input  logic                         wr_mem_arb_req_data_rdy,
  output logic [DATA_W-1:0]            arb_wr_mem_req_data,
  input  logic                         wr_mem_arb_wr_req_done,
  output logic                         arb_wr_mem_wr_req_done_rdy,
  output logic                         grant_val,
  output logic [ID_W-1:0]              grant_id
);
  localparam int BYTES = DATA_W / 8;
  localparam int LOG2B = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t              r_state, w_nxt;
  logic [ID_W-1:0]     r_rr_ptr, r_grant, w_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic [SIZE_W-1:0]   r_size, r_beats, w_sel_beats;
  logic [SIZE_W:0]     w_sum;
  logic                w_found, w_data_hs, w_done_hs;
  int                  w_idx;

  logic [NUM_SRCS-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_SRCS-1:0][SIZE_W-1:0] w_size;
  logic [NUM_SRCS-1:0][DATA_W-1:0] w_data;

  assign w_addr = src_wr_mem_req_addr;
  assign w_size = src_wr_mem_req_size;
  assign w_data = src_wr_mem_req_data;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_SRCS) w_idx = w_idx - NUM_SRCS;
      if (!w_found && src_wr_mem_req_val[w_idx]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(w_idx);
      end
    end
  end

  // One extra bit so ceil(size/BYTES) cannot overflow near the top of the size range.
  assign w_sum       = {1'b0, w_size[w_sel]} + (SIZE_W+1)'(BYTES - 1);
  assign w_sel_beats = SIZE_W'(w_sum >> LOG2B);

  always_comb begin
    w_nxt                      = r_state;
    w_data_hs                  = 1'b0;
    w_done_hs                  = 1'b0;
    wr_mem_src_req_rdy         = '0;
    wr_mem_src_req_data_rdy    = '0;
    wr_mem_src_wr_req_done     = '0;
    arb_wr_mem_req_val         = 1'b0;
    arb_wr_mem_req_data_val    = 1'b0;
    arb_wr_mem_wr_req_done_rdy = 1'b0;
    arb_wr_mem_req_data        = w_data[r_grant];
    case (r_state)
      IDLE: if (|src_wr_mem_req_val) w_nxt = REQ;
      REQ: begin
        arb_wr_mem_req_val = 1'b1;
        if (wr_mem_arb_req_rdy) begin
          wr_mem_src_req_rdy[r_grant] = 1'b1;
          w_nxt = (r_beats != '0) ? DATA : DONE;
        end
      end
      DATA: begin
        arb_wr_mem_req_data_val          = src_wr_mem_req_data_val[r_grant];
        wr_mem_src_req_data_rdy[r_grant] = wr_mem_arb_req_data_rdy;
        w_data_hs = src_wr_mem_req_data_val[r_grant] & wr_mem_arb_req_data_rdy;
        if (w_data_hs && r_beats == SIZE_W'(1)) w_nxt = DONE;
      end
      DONE: begin
        wr_mem_src_wr_req_done[r_grant] = wr_mem_arb_wr_req_done;
        arb_wr_mem_wr_req_done_rdy      = src_wr_mem_wr_req_done_rdy[r_grant];
        w_done_hs = wr_mem_arb_wr_req_done & src_wr_mem_wr_req_done_rdy[r_grant];
        if (w_done_hs) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_addr   <= '0;
      r_size   <= '0;
      r_beats  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && w_found) begin
        r_grant <= w_sel;
        r_addr  <= w_addr[w_sel];
        r_size  <= w_size[w_sel];
        r_beats <= w_sel_beats;
      end
      if (w_data_hs) r_beats <= r_beats - SIZE_W'(1);
      if (w_done_hs) r_rr_ptr <= (r_grant == ID_W'(NUM_SRCS - 1)) ? '0 : r_grant + ID_W'(1);
    end
  end

  assign arb_wr_mem_req_addr = r_addr;
  assign arb_wr_mem_req_size = r_size;
  assign grant_val           = (r_state != IDLE);
  assign grant_id            = grant_val ? r_grant : '0;

endmodule

// File: tb/tb_wr_mem_arb.sv
// Bench for wr_mem_arb: transaction table, directed corner sequences and random traffic
// checked every cycle against a transaction-level round-robin model.
module tb_wr_mem_arb;
  localparam int N = 3, AW = 32, SW = 16, DW = 512, BY = DW / 8, IW = 2;

  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    s_val, s_rdy, s_dval, s_drdy, s_done, s_done_rdy;
  logic [N*AW-1:0] s_addr;
  logic [N*SW-1:0] s_size;
  logic [N*DW-1:0] s_data;
  logic            m_val, m_rdy, m_dval, m_drdy, m_done, m_done_rdy, gv;
  logic [AW-1:0]   m_addr;
  logic [SW-1:0]   m_size;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   gid;

  wr_mem_arb #(.NUM_SRCS(N), .ADDR_W(AW), .SIZE_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_wr_mem_req_val(s_val), .wr_mem_src_req_rdy(s_rdy),
    .src_wr_mem_req_addr(s_addr), .src_wr_mem_req_size(s_size),
    .src_wr_mem_req_data_val(s_dval), .wr_mem_src_req_data_rdy(s_drdy),
    .src_wr_mem_req_data(s_data),
    .wr_mem_src_wr_req_done(s_done), .src_wr_mem_wr_req_done_rdy(s_done_rdy),
    .arb_wr_mem_req_val(m_val), .wr_mem_arb_req_rdy(m_rdy),
    .arb_wr_mem_req_addr(m_addr), .arb_wr_mem_req_size(m_size),
    .arb_wr_mem_req_data_val(m_dval), .wr_mem_arb_req_data_rdy(m_drdy),
    .arb_wr_mem_req_data(m_data),
    .wr_mem_arb_wr_req_done(m_done), .arb_wr_mem_wr_req_done_rdy(m_done_rdy),
    .grant_val(gv), .grant_id(gid)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  // source agents
  bit [N-1:0]    pend, in_txn, dv_en;
  logic [AW-1:0] a_addr [N];
  logic [SW-1:0] a_size [N];
  int            tag [N], bleft [N], bcnt [N], rearm [N];
  // transaction-level reference model
  bit            mb, m_reqd;
  int            mw, mrr, m_exp, m_seen;
  logic [AW-1:0] m_ea;
  logic [SW-1:0] m_es;
  // observations
  int obs_beats = 0, obs_done = 0, last_done_src = -1, t_val = -1;
  int gq[$];

  typedef struct { int src; logic [AW-1:0] addr; logic [SW-1:0] size; int beats; } vec_t;
  vec_t tbl [7];

  function automatic logic [DW-1:0] beat_data(int s, int t, int b);
    logic [31:0] w;
    w = 32'(s * 4096 + t * 64 + b) ^ 32'h5A5A_0000;
    return {(DW/32){w}};
  endfunction

  function automatic int nbeats(int sz);
    return (sz + BY - 1) / BY;
  endfunction

  function automatic logic [N-1:0] oh(int s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (m_val && t_val < 0) t_val = cyc;
    if (!mb) begin
      chk("idle_grant_val", gv, 0);
      chk("idle_grant_id", gid, 0);
      chk("idle_req_val", m_val, 0);
      chk("idle_data_val", m_dval, 0);
      chk("idle_done_rdy", m_done_rdy, 0);
      chk("idle_src_outputs", {s_rdy, s_drdy, s_done}, 0);
      if (|pend) begin
        mw = -1;
        for (int k = 0; k < N; k++) begin
          int s;
          s = (mrr + k) % N;
          if (mw < 0 && pend[s]) mw = s;
        end
        mb = 1; m_reqd = 0; m_seen = 0;
        m_exp = nbeats(int'(a_size[mw]));
        m_ea = a_addr[mw]; m_es = a_size[mw];
      end
    end else begin
      chk("grant_val", gv, 1);
      chk("grant_id", gid, mw);
      if (!m_reqd) begin
        chk("req_val", m_val, 1);
        chk("req_addr", m_addr, m_ea);
        chk("req_size", m_size, m_es);
        chk("req_rdy_route", s_rdy, m_rdy ? oh(mw) : '0);
        chk("req_phase_quiet", {m_dval, m_done_rdy, s_drdy, s_done}, 0);
        if (m_rdy) begin m_reqd = 1; gq.push_back(int'(gid)); end
      end else if (m_seen < m_exp) begin
        chk("data_phase_quiet", {m_val, m_done_rdy, s_rdy, s_done}, 0);
        chk("data_val_route", m_dval, s_dval[mw]);
        chk("data_rdy_route", s_drdy, m_drdy ? oh(mw) : '0);
        if (s_dval[mw] && m_drdy) begin
          chk("beat_data", m_data, beat_data(mw, tag[mw], m_seen));
          m_seen++; obs_beats++;
        end
      end else begin
        chk("done_phase_quiet", {m_val, m_dval, s_rdy, s_drdy}, 0);
        chk("done_route", s_done, m_done ? oh(mw) : '0);
        chk("done_rdy_route", m_done_rdy, s_done_rdy[mw]);
        if (m_done && s_done_rdy[mw]) begin
          mb = 0; mrr = (mw + 1) % N; obs_done++; last_done_src = mw;
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      if (s_val[s] && s_rdy[s]) begin
        pend[s] = 0; in_txn[s] = 1; bleft[s] = nbeats(int'(a_size[s])); bcnt[s] = 0;
      end
      if (s_dval[s] && s_drdy[s]) begin bleft[s]--; bcnt[s]++; end
      if (in_txn[s] && s_done[s] && s_done_rdy[s]) begin
        in_txn[s] = 0; tag[s]++;
        if (rearm[s] > 0) begin rearm[s]--; pend[s] = 1; end
      end
    end
  endtask

  task automatic step();
    for (int s = 0; s < N; s++) begin
      s_val[s]              = pend[s];
      s_addr[s*AW +: AW]    = a_addr[s];
      s_size[s*SW +: SW]    = a_size[s];
      s_dval[s]             = in_txn[s] && bleft[s] > 0 && dv_en[s];
      s_data[s*DW +: DW]    = beat_data(s, tag[s], bcnt[s]);
    end
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_agents();
    mb = 0; mrr = 0; pend = '0; in_txn = '0;
    for (int s = 0; s < N; s++) begin bleft[s] = 0; bcnt[s] = 0; rearm[s] = 0; end
    s_val = '0; s_dval = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_agents();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: memory and sources always ready; 1: data_rdy toggles; else random.
  task automatic run(int maxc, int mode, string nm);
    int i;
    i = 0;
    while ((mb || |pend || |in_txn) && i < maxc) begin
      if (mode == 0 || mode == 1) begin
        m_rdy = 1; m_done = 1; s_done_rdy = '1; dv_en = '1;
        m_drdy = (mode == 0) ? 1'b1 : (i % 2 == 0);
      end else begin
        m_rdy = ($urandom_range(0, 2) != 0); m_drdy = ($urandom_range(0, 2) != 0);
        m_done = ($urandom_range(0, 2) != 0); s_done_rdy = 3'($urandom);
        dv_en = 3'($urandom);
      end
      step();
      i++;
    end
    chk({nm, "_completes"}, {mb, |pend, |in_txn}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int b0, d0, t0, issued;
    rst_n = 1'b0;
    clear_agents();
    for (int s = 0; s < N; s++) begin a_addr[s] = '0; a_size[s] = '0; tag[s] = 0; end
    s_addr = '0; s_size = '0; s_data = '0;
    // Inputs all active during reset must be ignored.
    s_val = '1; s_dval = '1; s_done_rdy = '1; dv_en = '1;
    m_rdy = 1; m_drdy = 1; m_done = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_grant_val", gv, 0);
    chk("rst_grant_id", gid, 0);
    chk("rst_mem_outputs", {m_val, m_dval, m_done_rdy}, 0);
    chk("rst_src_outputs", {s_rdy, s_drdy, s_done}, 0);
    s_val = '0; s_dval = '0;
    rst_n = 1'b1;

    // Single transactions: latency, beat count (ceil), done routing.
    tbl = '{ '{0, 32'h100,  16'd128,    2}, '{1, 32'h2000, 16'd64,  1},
             '{2, 32'h40,   16'd65,     2}, '{0, 32'h80,   16'd1,   1},
             '{1, 32'h0,    16'd0,      0}, '{2, 32'hFFC0, 16'd192, 3},
             '{0, 32'h1234, 16'hFFFF, 1024} };
    for (int i = 0; i < 7; i++) begin
      int s;
      s = tbl[i].src;
      a_addr[s] = tbl[i].addr; a_size[s] = tbl[i].size; pend[s] = 1;
      t0 = cyc; t_val = -1; b0 = obs_beats; d0 = obs_done;
      run(3000, 0, "tbl");
      chk("tbl_req_latency", t_val - t0, 1);
      chk("tbl_beats", obs_beats - b0, tbl[i].beats);
      chk("tbl_done_count", obs_done - d0, 1);
      chk("tbl_done_src", last_done_src, s);
    end

    // Contention after reset, both re-requesting: 0,1,0,1.
    do_reset();
    a_size[0] = 64; a_size[1] = 64; a_addr[0] = 32'hA000; a_addr[1] = 32'hB000;
    rearm[0] = 1; rearm[1] = 1; gq.delete();
    pend[0] = 1; pend[1] = 1;
    run(300, 0, "contention");
    chk("contention_grants", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("contention_order", gq[k], k % 2);

    // Backpressure: data_rdy alternates, 192 bytes -> 3 beats in order.
    a_size[2] = 192; a_addr[2] = 32'hC000; pend[2] = 1; b0 = obs_beats;
    run(300, 1, "backpressure");
    chk("backpressure_beats", obs_beats - b0, 3);

    // Done stall: src0 holds done_rdy low; pending src1 must wait.
    gq.delete(); a_size[0] = 64; a_size[1] = 0;
    pend[0] = 1; pend[1] = 1;
    m_rdy = 1; m_drdy = 1; m_done = 1; dv_en = '1; s_done_rdy = 3'b110;
    for (int i = 0; i < 20 && !(mb && m_reqd && m_seen >= m_exp); i++) step();
    chk("stall_reached_done", mb && m_reqd && m_seen >= m_exp, 1);
    d0 = obs_done;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_owner", {gv, gid}, {1'b1, 2'd0});
      chk("stall_done_fwd", s_done, 3'b001);
    end
    chk("stall_no_done", obs_done - d0, 0);
    run(100, 0, "stall_release");
    chk("stall_grant_count", gq.size(), 2);
    if (gq.size() == 2) chk("stall_order", {gq[0][1:0], gq[1][1:0]}, {2'd0, 2'd1});

    // Mid-DATA reset: rr was 1, reset must bring it back to 0.
    do_reset();
    a_size[0] = 64; pend[0] = 1;
    run(100, 0, "pre_abort");
    a_size[1] = 256; pend[1] = 1; b0 = obs_beats;
    m_rdy = 1; m_drdy = 1; m_done = 1; s_done_rdy = '1; dv_en = '1;
    for (int i = 0; i < 20 && obs_beats - b0 < 1; i++) step();
    chk("abort_one_beat", obs_beats - b0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_grant_val", gv, 0);
    chk("abort_mem_outputs", {m_val, m_dval, m_done_rdy}, 0);
    chk("abort_src_outputs", {s_rdy, s_drdy, s_done}, 0);
    clear_agents();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    gq.delete(); a_size[0] = 64; a_size[1] = 64; pend[0] = 1; pend[1] = 1;
    run(100, 0, "post_abort");
    chk("post_abort_first", gq.size() > 0 ? gq[0] : -1, 0);

    // Random traffic against the model.
    issued = 0; d0 = obs_done;
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!pend[s] && !in_txn[s] && $urandom_range(0, 3) == 0) begin
          a_addr[s] = $urandom;
          case ($urandom_range(0, 4))
            0:       a_size[s] = 0;
            1:       a_size[s] = 64;
            2:       a_size[s] = 65;
            3:       a_size[s] = SW'($urandom_range(1, 512));
            default: a_size[s] = 128;
          endcase
          pend[s] = 1; issued++;
        end
      end
      m_rdy = ($urandom_range(0, 2) != 0); m_drdy = ($urandom_range(0, 2) != 0);
      m_done = ($urandom_range(0, 2) != 0); s_done_rdy = 3'($urandom);
      dv_en = 3'($urandom);
      step();
    end
    run(5000, 2, "random_drain");
    chk("random_completions", obs_done - d0, issued);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wr_mem_arb.md
WR_MEM_ARB -- requirements
Module: wr_mem_arb

Interface
REQ-001 Parameter NUM_SRCS, 2, number of write requesters sharing one write-memory port (2..8).
REQ-002 Parameter ADDR_W, 32, request address width.
REQ-003 Parameter SIZE_W, 16, request size width, in bytes.
REQ-004 Parameter DATA_W, 512, data beat width; BYTES = DATA_W/8, a power of two.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 src_wr_mem_req_val / wr_mem_src_req_rdy  in/out  NUM_SRCS each  per-source request handshake.
REQ-008 src_wr_mem_req_addr / src_wr_mem_req_size  in  NUM_SRCS*ADDR_W / NUM_SRCS*SIZE_W  packed per-source request fields.
REQ-009 src_wr_mem_req_data_val / wr_mem_src_req_data_rdy  in/out  NUM_SRCS each  per-source data handshake.
REQ-010 src_wr_mem_req_data  in  NUM_SRCS*DATA_W  packed per-source data.
REQ-011 wr_mem_src_wr_req_done / src_wr_mem_wr_req_done_rdy  out/in  NUM_SRCS each  per-source completion handshake.
REQ-012 arb_wr_mem_req_val / wr_mem_arb_req_rdy, arb_wr_mem_req_addr (ADDR_W), arb_wr_mem_req_size (SIZE_W)  out/in/out/out  shared memory request.
REQ-013 arb_wr_mem_req_data_val / wr_mem_arb_req_data_rdy, arb_wr_mem_req_data (DATA_W)  out/in/out  shared memory data.
REQ-014 wr_mem_arb_wr_req_done / arb_wr_mem_wr_req_done_rdy  in/out  1  shared memory completion.
REQ-015 grant_val / grant_id  out  1 / clog2(NUM_SRCS)  current owner, for debug and perf counters.

Function
REQ-016 FSM states: IDLE, REQ, DATA, DONE; at most one transaction owns the memory port, from grant through the done handshake.
REQ-017 IDLE: if any src req_val is high, latch grant_reg as the first asserted source at or after rr_ptr (round robin, wrapping), latch the selected addr/size, and load beats_rem = ceil(size/BYTES); go to REQ; otherwise stay.
REQ-018 REQ: arb_wr_mem_req_val=1 with the latched addr/size. On wr_mem_arb_req_rdy, pulse wr_mem_src_req_rdy[grant_reg] in the same cycle. Next state is DATA if beats_rem!=0, else DONE.
REQ-019 Sources hold req_val and fields stable until their req_rdy; a source dropping req_val before grant is never granted.
REQ-020 DATA: pure combinational pass-through. arb data_val = src data_val[grant_reg], arb data = src data[grant_reg], wr_mem_src_req_data_rdy[grant_reg] = wr_mem_arb_req_data_rdy; non-granted data_rdy = 0.
REQ-021 DATA: on each data handshake, decrement beats_rem; on the handshake with beats_rem==1, go to DONE.
REQ-022 DONE: wr_mem_src_wr_req_done[grant_reg] = wr_mem_arb_wr_req_done; arb_wr_mem_wr_req_done_rdy = src done_rdy[grant_reg]. On handshake, set rr_ptr = grant_reg+1 (mod NUM_SRCS) and go to IDLE.
REQ-023 Minimum per-transaction overhead: 1 IDLE cycle before the memory sees req_val; back-to-back transactions are separated by exactly 1 IDLE cycle.
REQ-024 grant_val=1 in REQ, DATA and DONE; grant_id = grant_reg.
REQ-025 All per-source outputs for non-granted sources are 0 in every state. All outputs are 0 in IDLE, except that bus fields may take any value.
REQ-026 beats_rem width is SIZE_W; size values that are not a multiple of BYTES round up, e.g. size 65 with BYTES 64 gives 2 beats.
REQ-027 Simultaneous requests in IDLE: exactly one source is granted per REQ-017; the others wait without loss.
REQ-028 Memory-side ready/done asserted outside the matching state is ignored.

Reset
REQ-029 While rst_n=0: state=IDLE, rr_ptr=0, grant_reg=0, beats_rem=0, all val/rdy/done outputs and grant_val = 0.
REQ-030 Reset asserted mid-transaction aborts it immediately and asynchronously; no done is delivered for the aborted transaction.

Verification
REQ-031 Single request: src0 addr 0x100, size 128, memory always ready -> req_val at cycle 1, 2 data beats, done forwarded to src0, back in IDLE.
REQ-032 Contention: src0 and src1 request in the same cycle after reset -> src0 granted first, src1 next; with both re-requesting, grants alternate 0,1,0,1.
REQ-033 Zero size: size 0 -> REQ goes directly to DONE; no data_val is ever asserted.
REQ-034 Backpressure: data_rdy toggles 1,0,1,0 and size 192 -> exactly 3 beats transferred in order, source data_rdy mirrors memory rdy, and no beat is duplicated.
REQ-035 Done stall: src done_rdy held 0 for 5 cycles -> FSM stays in DONE and a pending src1 request is not granted until the handshake.
REQ-036 Mid-DATA reset: rst_n low after beat 1 of 4 -> all outputs 0 immediately, and the next request is granted from rr_ptr=0.
